// File: rtl/linebuff_pool_ctrl.sv
// Sequencer for the conv1 pooling line-buffer array: accepts the word stream,
// drives the shared shift enable and flags each completed vertical pooling window.
module linebuff_pool_ctrl #(
  parameter int COLS   = 7,
  parameter int ROWS   = 28,
  parameter int POOL_K = 2,
  parameter int CW     = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          pool_ctrl_clk,
  input  logic          pool_ctrl_rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_pool_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] PH_LAST  = RW'(POOL_K - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_ph;
  logic [RW-1:0] r_prow;
  logic          r_out_valid;
  logic [RW-1:0] r_out_row;
  logic [CW-1:0] r_out_col;
  logic          r_out_last;
  logic          r_busy;
  logic          r_done;

  logic w_accept;
  logic w_row_end;
  logic w_frame_end;
  logic w_win;

  assign in_ready    = (r_state == S_RUN) & (~r_out_valid | out_ready);
  assign w_accept    = in_valid & in_ready;
  assign lb_pool_en  = w_accept;
  assign w_row_end   = (r_col == COL_LAST);
  assign w_frame_end = w_row_end & (r_row == ROW_LAST);
  // r_ph tracks row % POOL_K and r_prow tracks row / POOL_K, avoiding a divider
  assign w_win       = w_accept & (r_ph == PH_LAST);

  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept & w_frame_end) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_out_valid & out_ready) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pool_ctrl_clk or posedge pool_ctrl_rst) begin
    if (pool_ctrl_rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_ph        <= '0;
      r_prow      <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);

      if ((r_state == S_IDLE) && start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_ph   <= '0;
        r_prow <= '0;
      end else if (w_accept) begin
        if (w_frame_end) begin
          r_col  <= '0;
          r_row  <= '0;
          r_ph   <= '0;
          r_prow <= '0;
        end else if (w_row_end) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
          if (r_ph == PH_LAST) begin
            r_ph   <= '0;
            r_prow <= r_prow + 1'b1;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      // A new window on the same edge as a take replaces the old one
      if (w_win) begin
        r_out_valid <= 1'b1;
        r_out_row   <= r_prow;
        r_out_col   <= r_col;
        r_out_last  <= w_frame_end;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_linebuff_pool_ctrl.sv
// Randomized bench for linebuff_pool_ctrl against a word-count based reference model,
// with a default instance and a COLS=4/ROWS=6/POOL_K=3 instance.
module tb_linebuff_pool_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic       a_ir, a_lb, a_ov, a_last, a_busy, a_done;
  logic [4:0] a_row;
  logic [2:0] a_col;
  logic       b_ir, b_lb, b_ov, b_last, b_busy, b_done;
  logic [2:0] b_row;
  logic [1:0] b_col;

  linebuff_pool_ctrl u_dut_a (
    .pool_ctrl_clk(clk), .pool_ctrl_rst(rst), .start(start & ~sel),
    .in_valid(in_valid), .in_ready(a_ir), .lb_pool_en(a_lb),
    .out_valid(a_ov), .out_ready(out_ready), .out_row(a_row), .out_col(a_col),
    .out_last(a_last), .busy(a_busy), .done(a_done)
  );

  linebuff_pool_ctrl #(.COLS(4), .ROWS(6), .POOL_K(3)) u_dut_b (
    .pool_ctrl_clk(clk), .pool_ctrl_rst(rst), .start(start & sel),
    .in_valid(in_valid), .in_ready(b_ir), .lb_pool_en(b_lb),
    .out_valid(b_ov), .out_ready(out_ready), .out_row(b_row), .out_col(b_col),
    .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  logic o_ir, o_lb, o_ov, o_last, o_busy, o_done;
  int   o_row, o_col;
  assign o_ir   = sel ? b_ir   : a_ir;
  assign o_lb   = sel ? b_lb   : a_lb;
  assign o_ov   = sel ? b_ov   : a_ov;
  assign o_last = sel ? b_last : a_last;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_row  = sel ? int'(b_row) : int'(a_row);
  assign o_col  = sel ? int'(b_col) : int'(a_col);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: frame progress expressed as accepted-word and taken-window counts
  int cols = 7, rows = 28, pk = 2;
  bit m_active, m_done;
  int acc, taken;
  bit pend_v, pend_l;
  int pend_r, pend_c;
  int dut_win, lb_cnt, last_r, last_c;

  task automatic model_reset();
    m_active = 0; m_done = 0; acc = 0; taken = 0; pend_v = 0;
  endtask

  always @(negedge clk) begin
    int total, nwin, r, c;
    bit exp_ir, take, was_active;
    if (rst) begin
      model_reset();
    end else begin
      total = cols * rows;
      nwin  = (rows / pk) * cols;
      was_active = m_active;
      exp_ir = m_active && (acc < total) && (!pend_v || out_ready);
      check_eq("in_ready", int'(o_ir), int'(exp_ir));
      check_eq("lb_pool_en", int'(o_lb), int'(in_valid && exp_ir));
      check_eq("out_valid", int'(o_ov), int'(pend_v));
      check_eq("busy", int'(o_busy), int'(m_active));
      check_eq("done", int'(o_done), int'(m_done));
      if (pend_v) begin
        check_eq("out_row", o_row, pend_r);
        check_eq("out_col", o_col, pend_c);
        check_eq("out_last", int'(o_last), int'(pend_l));
      end
      if (o_lb) lb_cnt++;
      take = pend_v && out_ready;
      if (take) begin
        check_eq("seq_row", o_row, taken / cols);
        check_eq("seq_col", o_col, taken % cols);
        if (o_last) begin last_r = o_row; last_c = o_col; end
        taken++;
      end
      if (o_ov && out_ready) dut_win++;
      if (in_valid && exp_ir) begin
        r = acc / cols;
        c = acc % cols;
        if (r % pk == pk - 1) begin
          pend_v = 1; pend_r = r / pk; pend_c = c; pend_l = (acc == total - 1);
        end else if (take) begin
          pend_v = 0;
        end
        acc++;
      end else if (take) begin
        pend_v = 0;
      end
      if (m_done) begin
        m_done = 0; m_active = 0;
      end else if (m_active && take && taken == nwin) begin
        m_done = 1;
      end
      if (!was_active && start) begin
        m_active = 1; acc = 0; taken = 0;
        dut_win = 0; lb_cnt = 0; last_r = -1; last_c = -1;
      end
    end
  end

  // mode 0: full throughput, 1: stall at window (3,2), 2: random gaps and stray starts
  task automatic run_frame(input int mode, input int budget, output bit bp_seen);
    int  hold;
    bit  seen_done;
    hold = 0; bp_seen = 0; seen_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
      case (mode)
        0: begin in_valid = 1'b1; out_ready = 1'b1; end
        1: begin
          in_valid = 1'b1;
          if (!bp_seen && o_ov && o_row == 3 && o_col == 2) begin
            bp_seen = 1; hold = 5;
          end
          out_ready = (hold == 0);
          if (hold > 0) hold--;
        end
        default: begin
          in_valid  = ($urandom_range(0, 1) == 1);
          out_ready = ($urandom_range(0, 3) != 0);
          start     = ($urandom_range(0, 15) == 0) || o_done;
        end
      endcase
      if (o_done) seen_done = 1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq("frame_done", int'(seen_done), 1);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame_stats(input int exp_win, input int exp_lr, input int exp_lc);
    check_eq("win_cnt", dut_win, exp_win);
    check_eq("lb_cnt", lb_cnt, cols * rows);
    check_eq("last_row", last_r, exp_lr);
    check_eq("last_col", last_c, exp_lc);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ir"}, int'(o_ir), 0);
    check_eq({tag, "_lb"}, int'(o_lb), 0);
    check_eq({tag, "_ov"}, int'(o_ov), 0);
    check_eq({tag, "_row"}, o_row, 0);
    check_eq({tag, "_col"}, o_col, 0);
    check_eq({tag, "_last"}, int'(o_last), 0);
    check_eq({tag, "_busy"}, int'(o_busy), 0);
    check_eq({tag, "_done"}, int'(o_done), 0);
  endtask

  initial begin
    bit bp;
    bit reached;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst");
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 400, bp);
    frame_stats(98, 13, 6);

    run_frame(1, 400, bp);
    check_eq("bp_hit", int'(bp), 1);
    frame_stats(98, 13, 6);

    run_frame(2, 4000, bp);
    frame_stats(98, 13, 6);
    run_frame(2, 4000, bp);
    frame_stats(98, 13, 6);

    // Asynchronous reset in the middle of row 9
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    reached = 0;
    for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
      @(posedge clk); #1;
      if (acc >= 9 * 7 + 3) reached = 1;
    end
    check_eq("mid_row9", int'(reached), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 400, bp);
    frame_stats(98, 13, 6);

    // Overridden-parameter instance
    rst = 1'b1;
    @(posedge clk); #1;
    sel = 1'b1; cols = 4; rows = 6; pk = 3;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 200, bp);
    frame_stats(8, 1, 3);
    run_frame(2, 1000, bp);
    frame_stats(8, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
